// File: rtl/avg_line_raster.sv
`default_nettype none
// =============================================================================
// avg_line_raster : segment FIFO feeding a Bresenham rasteriser that issues
//                   clipped framebuffer pixel writes over valid/ready.
// Revision: 1.0
// =============================================================================
module avg_line_raster #(
  parameter int FIFO_DEPTH = 8,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int X_OFF      = 320,
  parameter int Y_OFF      = 240
) (
  input  logic        clk_in,
  input  logic        rst_b,
  input  logic [12:0] startX,
  input  logic [12:0] startY,
  input  logic [12:0] endX,
  input  logic [12:0] endY,
  input  logic [3:0]  intensity,
  input  logic        lrWrite,
  input  logic        frameClr,
  output logic [9:0]  pixX,
  output logic [8:0]  pixY,
  output logic [3:0]  pixZ,
  output logic        pixValid,
  input  logic        pixReady,
  output logic        busy,
  output logic        overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int SEG_W = 56;
  localparam logic [AW:0]        C_PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0]        C_FULL    = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [14:0] C_XOFF    = 15'(X_OFF);
  localparam logic signed [14:0] C_YOFF    = 15'(Y_OFF);
  localparam logic signed [14:0] C_HRES    = 15'(H_RES);
  localparam logic signed [14:0] C_VRES    = 15'(V_RES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SETUP = 2'd2,
    S_DRAW  = 2'd3
  } state_t;

  state_t r_state;

  logic [SEG_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic signed [14:0] r_x0, r_y0, r_x1, r_y1;
  logic signed [14:0] r_cx, r_cy;
  logic signed [14:0] r_dx, r_dy, r_err;
  logic signed [14:0] r_sx, r_sy;
  logic [3:0]         r_z;

  logic [AW:0]        w_count;
  logic               w_empty, w_full, w_pop, w_push, w_drop;
  logic [SEG_W-1:0]   w_head;

  logic signed [14:0] w_ddx, w_ddy, w_adx, w_ady, w_sgnx, w_sgny;
  logic signed [15:0] w_e2, w_dx16, w_dy16;
  logic               w_mx, w_my, w_clip, w_step, w_at_end;
  logic signed [14:0] w_nx, w_ny, w_nerr;

  function automatic logic signed [14:0] f_sext(input logic [12:0] v);
    return $signed({{2{v[12]}}, v});
  endfunction

  function automatic logic f_in(input logic signed [14:0] x, input logic signed [14:0] y);
    return (x >= 15'sd0) && (x < C_HRES) && (y >= 15'sd0) && (y < C_VRES);
  endfunction

  // Pop only from IDLE; a push into a full FIFO is legal when that pop frees a slot.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == C_FULL);
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !frameClr;
  assign w_push  = lrWrite && !frameClr && (!w_full || w_pop);
  assign w_drop  = lrWrite && !frameClr && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_ddx  = r_x1 - r_x0;
  assign w_ddy  = r_y1 - r_y0;
  assign w_adx  = w_ddx[14] ? -w_ddx : w_ddx;
  assign w_ady  = w_ddy[14] ? -w_ddy : w_ddy;
  assign w_sgnx = (w_ddx == 15'sd0) ? 15'sd0 : (w_ddx[14] ? -15'sd1 : 15'sd1);
  assign w_sgny = (w_ddy == 15'sd0) ? 15'sd0 : (w_ddy[14] ? -15'sd1 : 15'sd1);

  // Both axis decisions compare against the pre-step error term.
  assign w_e2     = {r_err, 1'b0};
  assign w_dx16   = {r_dx[14], r_dx};
  assign w_dy16   = {r_dy[14], r_dy};
  assign w_mx     = (w_e2 >= w_dy16);
  assign w_my     = (w_e2 <= w_dx16);
  assign w_nx     = r_cx + (w_mx ? r_sx : 15'sd0);
  assign w_ny     = r_cy + (w_my ? r_sy : 15'sd0);
  assign w_nerr   = r_err + (w_mx ? r_dy : 15'sd0) + (w_my ? r_dx : 15'sd0);
  assign w_clip   = !f_in(r_cx, r_cy);
  assign w_step   = (pixValid && pixReady) || w_clip;
  assign w_at_end = (r_cx == r_x1) && (r_cy == r_y1);

  assign busy = !w_empty || (r_state != S_IDLE) || pixValid;

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {startX, startY, endX, endY, intensity};
    end
  end

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      overflow <= 1'b0;
    end else if (frameClr) begin
      r_rd_ptr <= r_wr_ptr;
      overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      if (w_drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= S_IDLE;
      r_x0     <= '0;
      r_y0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx     <= '0;
      r_sy     <= '0;
      r_z      <= '0;
      pixX     <= '0;
      pixY     <= '0;
      pixZ     <= '0;
      pixValid <= 1'b0;
    end else if (frameClr) begin
      r_state  <= S_IDLE;
      pixValid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_x0    <= f_sext(w_head[55:43]);
            r_y0    <= f_sext(w_head[42:30]);
            r_x1    <= f_sext(w_head[29:17]);
            r_y1    <= f_sext(w_head[16:4]);
            r_z     <= w_head[3:0];
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Screen y grows downward while vector y grows upward.
          r_x0    <= r_x0 + C_XOFF;
          r_x1    <= r_x1 + C_XOFF;
          r_y0    <= C_YOFF - r_y0;
          r_y1    <= C_YOFF - r_y1;
          r_state <= (r_z == 4'd0) ? S_IDLE : S_SETUP;
        end
        S_SETUP: begin
          r_dx     <= w_adx;
          r_dy     <= -w_ady;
          r_err    <= w_adx - w_ady;
          r_sx     <= w_sgnx;
          r_sy     <= w_sgny;
          r_cx     <= r_x0;
          r_cy     <= r_y0;
          pixX     <= r_x0[9:0];
          pixY     <= r_y0[8:0];
          pixZ     <= r_z;
          pixValid <= f_in(r_x0, r_y0);
          r_state  <= S_DRAW;
        end
        S_DRAW: begin
          if (w_step) begin
            if (w_at_end) begin
              pixValid <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_cx     <= w_nx;
              r_cy     <= w_ny;
              r_err    <= w_nerr;
              pixX     <= w_nx[9:0];
              pixY     <= w_ny[8:0];
              pixValid <= f_in(w_nx, w_ny);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avg_line_raster.sv
`default_nettype none
// =============================================================================
// tb_avg_line_raster : directed scoreboard bench for avg_line_raster.
// Revision: 1.0
// =============================================================================
module tb_avg_line_raster;

  logic        clk_in = 1'b0;
  logic        rst_b = 1'b0;
  logic [12:0] startX = '0, startY = '0, endX = '0, endY = '0;
  logic [3:0]  intensity = '0;
  logic        lrWrite = 1'b0, frameClr = 1'b0, pixReady = 1'b1;
  logic [9:0]  pixX;
  logic [8:0]  pixY;
  logic [3:0]  pixZ;
  logic        pixValid, busy, overflow;

  int checks = 0, errors = 0, valid_cycles = 0, stall_cycles = 0;
  logic [22:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [22:0] prev_pix = '0;

  avg_line_raster #(.FIFO_DEPTH(8), .H_RES(640), .V_RES(480), .X_OFF(320), .Y_OFF(240)) dut (
    .clk_in(clk_in), .rst_b(rst_b),
    .startX(startX), .startY(startY), .endX(endX), .endY(endY),
    .intensity(intensity), .lrWrite(lrWrite), .frameClr(frameClr),
    .pixX(pixX), .pixY(pixY), .pixZ(pixZ), .pixValid(pixValid),
    .pixReady(pixReady), .busy(busy), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: pops the scoreboard on every accepted pixel and checks stall stability.
  always @(negedge clk_in) begin
    if (!rst_b) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!pixValid || ({pixX, pixY, pixZ} != prev_pix)) begin
          errors++;
          $display("FAIL hold: got valid=%0b (%0d,%0d,z%0d) required (%0d,%0d,z%0d)", pixValid,
                   pixX, pixY, pixZ, prev_pix[22:13], prev_pix[12:4], prev_pix[3:0]);
        end
      end
      if (pixValid) valid_cycles++;
      if (pixValid && !pixReady) stall_cycles++;
      if (pixValid && pixReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel: got unexpected (%0d,%0d,z%0d) required none", pixX, pixY, pixZ);
        end else begin
          logic [22:0] e;
          e = exp_q.pop_front();
          if ({pixX, pixY, pixZ} != e) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d,z%0d) required (%0d,%0d,z%0d)", pixX, pixY, pixZ,
                     e[22:13], e[12:4], e[3:0]);
          end
        end
      end
      prev_stall = pixValid && !pixReady;
      prev_pix   = {pixX, pixY, pixZ};
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic expect_pix(input int x, input int y, input int z);
    exp_q.push_back({10'(x), 9'(y), 4'(z)});
  endtask

  task automatic seg(input int sx, input int sy, input int ex, input int ey, input int z,
                     input bit clr);
    startX = 13'(sx); startY = 13'(sy); endX = 13'(ex); endY = 13'(ey);
    intensity = 4'(z); lrWrite = 1'b1; frameClr = clr;
    @(posedge clk_in); #1;
    lrWrite = 1'b0; frameClr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    chk({name, " drained"}, int'(busy), 0);
    chk({name, " scoreboard empty"}, exp_q.size(), 0);
    @(posedge clk_in); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    @(negedge clk_in); @(negedge clk_in);
    chk("rst pixValid", int'(pixValid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst overflow", int'(overflow), 0);
    chk("rst pixXYZ", int'({pixX, pixY, pixZ}), 0);
    @(posedge clk_in); #1;
    rst_b = 1'b1;
    @(posedge clk_in); #1;

    // Single segment: latency of 3 edges, 4 back-to-back pixels, then busy falls
    expect_pix(320, 240, 9); expect_pix(321, 240, 9);
    expect_pix(322, 239, 9); expect_pix(323, 239, 9);
    seg(0, 0, 3, 1, 9, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk($sformatf("latency edge+%0d", k), int'(pixValid), (k == 3) ? 1 : 0);
    end
    repeat (4) @(negedge clk_in);
    chk("single busy fall", int'(busy), 0);
    chk("single scoreboard empty", exp_q.size(), 0);
    @(posedge clk_in); #1;

    // Backpressure on the 2nd pixel for 5 cycles
    valid_cycles = 0; stall_cycles = 0;
    expect_pix(320, 240, 9); expect_pix(321, 240, 9);
    expect_pix(322, 239, 9); expect_pix(323, 239, 9);
    seg(0, 0, 3, 1, 9, 0);
    repeat (4) @(posedge clk_in);
    #1 pixReady = 1'b0;
    repeat (5) @(posedge clk_in);
    #1 pixReady = 1'b1;
    wait_idle("bp");
    chk("bp draw cycles", valid_cycles, 9);
    chk("bp stall cycles", stall_cycles, 5);

    // Clipping on the left edge
    valid_cycles = 0;
    expect_pix(0, 240, 5); expect_pix(1, 240, 5); expect_pix(2, 240, 5);
    seg(-330, 0, -318, 0, 5, 0);
    wait_idle("clip");
    chk("clip valid cycles", valid_cycles, 3);

    // Degenerate, blank, then visible segment
    valid_cycles = 0;
    expect_pix(325, 235, 3); expect_pix(321, 239, 7);
    seg(5, 5, 5, 5, 3, 0);
    seg(10, 10, 20, 20, 0, 0);
    seg(1, 1, 1, 1, 7, 0);
    wait_idle("blank");
    chk("blank valid cycles", valid_cycles, 2);

    // Overflow: 1 in working registers, 8 queued, 10th dropped
    pixReady = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 9) expect_pix(320 + k, 240, k);
      seg(k, 0, k, 0, k, 0);
    end
    @(negedge clk_in);
    chk("overflow set", int'(overflow), 1);
    @(posedge clk_in); #1;
    pixReady = 1'b1;
    wait_idle("overflow");
    chk("overflow sticky", int'(overflow), 1);

    // frameClr mid-line with 3 queued segments and a simultaneous lrWrite
    expect_pix(320, 240, 1); expect_pix(321, 240, 1);
    for (int k = 0; k < 4; k++) seg(0, 0, 50, 0, 1, 0);
    @(posedge clk_in); #1;
    seg(60, 0, 70, 0, 2, 1);
    @(negedge clk_in);
    chk("clr pixValid", int'(pixValid), 0);
    chk("clr busy", int'(busy), 0);
    chk("clr overflow", int'(overflow), 0);
    valid_cycles = 0;
    repeat (10) @(negedge clk_in);
    chk("clr no pixels", valid_cycles, 0);
    chk("clr busy stays low", int'(busy), 0);
    chk("clr scoreboard empty", exp_q.size(), 0);
    @(posedge clk_in); #1;

    // Asynchronous reset in the middle of a stalled line
    pixReady = 1'b0;
    seg(0, 0, 20, 0, 4, 0);
    repeat (6) @(posedge clk_in);
    #3 rst_b = 1'b0;
    #1;
    chk("async rst pixValid", int'(pixValid), 0);
    chk("async rst busy", int'(busy), 0);
    chk("async rst pixX", int'(pixX), 0);
    @(posedge clk_in); #1;
    rst_b = 1'b1;
    pixReady = 1'b1;
    valid_cycles = 0;
    repeat (6) @(negedge clk_in);
    chk("post rst no pixels", valid_cycles, 0);
    chk("final scoreboard empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
